// File: rtl/sram_sp_req_ctrl_if.sv
// Request/response stream plus single-port SRAM macro pins for sram_sp_req_ctrl.
// master = bus-slave logic and macro side, slave = the request controller.
interface sram_sp_req_ctrl_if #(
    parameter int AW = 13,
    parameter int DW = 32
) ();
    localparam int NB = DW / 8;

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [NB-1:0] req_be;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    logic          sram_cen_n;
    logic          sram_gwen_n;
    logic [NB-1:0] sram_ben_n;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready, sram_q,
        input  req_ready, rsp_valid, rsp_rdata,
        input  sram_cen_n, sram_gwen_n, sram_ben_n, sram_a, sram_d
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready, sram_q,
        output req_ready, rsp_valid, rsp_rdata,
        output sram_cen_n, sram_gwen_n, sram_ben_n, sram_a, sram_d
    );
endinterface

// File: rtl/sram_sp_req_ctrl.sv
// Single-port SRAM request controller: valid/ready requests to macro cycles, in-order read responses.
// Optional SRAM_SP_REQ_CTRL_RDBUF2_EN: two-entry response buffer for full-rate back-to-back reads.
module sram_sp_req_ctrl #(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    sram_sp_req_ctrl_if.slave    bus
);
    localparam int NB = DW / 8;
`ifdef SRAM_SP_REQ_CTRL_RDBUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int         PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] DEPTH_C  = 2'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic          rd_pend_r;
    logic [1:0]    count_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [DW-1:0] rbuf_r [DEPTH];
    logic          rsp_valid_r;

    logic          rsp_fire_s;
    logic          acc_s;
    logic          rd_acc_s;
    logic          wr_acc_s;
    logic          macro_acc_s;
    logic          req_ready_s;
    logic [1:0]    outstanding_s;
    logic [1:0]    count_nxt_s;

    logic          sram_cen_n_s;
    logic          sram_gwen_n_s;
    logic [NB-1:0] sram_ben_n_s;
    logic [AW-1:0] sram_a_s;
    logic [DW-1:0] sram_d_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PTR_LAST) begin
            r = {PW{1'b0}};
        end else begin
            r = p + {{(PW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Credit check: a read needs a free buffer slot counting the read still in the macro.
    always_comb begin
        outstanding_s = {1'b0, rd_pend_r} + count_r;
        rsp_fire_s    = rsp_valid_r & bus.rsp_ready;
        req_ready_s   = 1'b0;
        if (bus.req_write) begin
            req_ready_s = 1'b1;
        end else if (outstanding_s < DEPTH_C) begin
            req_ready_s = 1'b1;
        end else if ((outstanding_s == DEPTH_C) && rsp_fire_s) begin
            req_ready_s = 1'b1;
        end else begin
            req_ready_s = 1'b0;
        end
        acc_s       = bus.req_valid & req_ready_s;
        rd_acc_s    = acc_s & ~bus.req_write;
        wr_acc_s    = acc_s & bus.req_write & (|bus.req_be);
        macro_acc_s = rd_acc_s | wr_acc_s;
    end

    // Macro pins follow the accepted request in the same cycle; an all-zero-enable write stays idle.
    always_comb begin
        sram_cen_n_s  = 1'b1;
        sram_gwen_n_s = 1'b1;
        sram_ben_n_s  = {NB{1'b1}};
        sram_a_s      = {AW{1'b0}};
        sram_d_s      = {DW{1'b0}};
        if (macro_acc_s && RESETn) begin
            sram_cen_n_s = 1'b0;
            sram_a_s     = bus.req_addr;
            sram_d_s     = bus.req_wdata;
            if (bus.req_write) begin
                sram_gwen_n_s = 1'b0;
                sram_ben_n_s  = ~bus.req_be;
            end else begin
                sram_gwen_n_s = 1'b1;
                sram_ben_n_s  = {NB{1'b1}};
            end
        end else begin
            sram_cen_n_s  = 1'b1;
            sram_gwen_n_s = 1'b1;
        end
    end

    // Buffer occupancy after this cycle's push (macro data returning) and pop (consumer accept).
    always_comb begin
        count_nxt_s = count_r;
        case ({rd_pend_r, rsp_fire_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Read pipeline: capture sram_q the cycle after the access, pop in order.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rd_pend_r   <= 1'b0;
            count_r     <= 2'd0;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            rsp_valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rbuf_r[i] <= {DW{1'b0}};
            end
        end else begin
            rd_pend_r   <= rd_acc_s;
            count_r     <= count_nxt_s;
            rsp_valid_r <= (count_nxt_s != 2'd0);
            if (rd_pend_r) begin
                rbuf_r[wr_ptr_r] <= bus.sram_q;
                wr_ptr_r         <= ptr_inc(wr_ptr_r);
            end
            if (rsp_fire_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rbuf_r[rd_ptr_r];
    assign bus.sram_cen_n  = sram_cen_n_s;
    assign bus.sram_gwen_n = sram_gwen_n_s;
    assign bus.sram_ben_n  = sram_ben_n_s;
    assign bus.sram_a      = sram_a_s;
    assign bus.sram_d      = sram_d_s;
endmodule

// File: tb/tb_sram_sp_req_ctrl.sv
// Testbench for sram_sp_req_ctrl: cycle table for macro drive and read data, plus streaming,
// backpressure and reset sequences against a behavioural single-port SRAM.
module tb_sram_sp_req_ctrl;
`ifdef SRAM_SP_REQ_CTRL_RDBUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    sram_sp_req_ctrl_if #(.AW(13), .DW(32)) bus ();

    sram_sp_req_ctrl #(.AW(13), .DW(32)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    // Behavioural macro: background contents 0xC0DE0000 | address.
    logic [31:0] mem [0:8191];
    logic [31:0] sram_q_r = 32'd0;
    always @(posedge CLK) begin
        if (!bus.sram_cen_n) begin
            if (!bus.sram_gwen_n) begin
                for (int b = 0; b < 4; b++) begin
                    if (!bus.sram_ben_n[b]) mem[bus.sram_a][b*8 +: 8] = bus.sram_d[b*8 +: 8];
                end
            end else begin
                sram_q_r <= mem[bus.sram_a];
            end
        end
    end
    assign bus.sram_q = sram_q_r;

    typedef struct {
        logic        valid;
        logic        write;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        e_ready;
        logic        e_cen_n;
        logic        e_gwen_n;
        logic [3:0]  e_ben_n;
        logic [12:0] e_a;
        logic [31:0] e_d;
        logic        e_rsp_valid;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b1;
        bus.req_addr  = 13'd0;
        bus.req_wdata = 32'd0;
        bus.req_be    = 4'd0;
    endtask

    // Read stream of n words from base; rsp_ready low for the first 'hold' cycles.
    task automatic run_stream(input logic [12:0] base, input int n, input int hold,
                              input int exp_early, input int exp_last);
        int n_acc = 0;
        int n_rsp = 0;
        int cen_lo = 0;
        int acc_early = 0;
        int last_rsp = -1;
        for (int cyc = 0; cyc < 80 && n_rsp < n; cyc++) begin
            @(posedge CLK); #1;
            bus.req_valid = (n_acc < n);
            bus.req_write = 1'b0;
            bus.req_addr  = base + 13'(n_acc);
            bus.req_wdata = 32'd0;
            bus.req_be    = 4'd0;
            bus.rsp_ready = (cyc >= hold);
            @(negedge CLK);
            if (!bus.sram_cen_n) cen_lo++;
            if (bus.req_valid && bus.req_ready) begin
                n_acc++;
                if (cyc < 8) acc_early++;
            end
            if (bus.rsp_valid) begin
                check("stream_rdata", bus.rsp_rdata, 32'hC0DE_0000 | 32'(base + 13'(n_rsp)));
                if (bus.rsp_ready) begin
                    n_rsp++;
                    last_rsp = cyc;
                end
            end
            if (cyc == hold - 1) begin
                check("hold_accepts", 32'(n_acc), 32'(DEPTH));
                check("hold_cen_lo", 32'(cen_lo), 32'(DEPTH));
            end
        end
        check("stream_rsp_count", 32'(n_rsp), 32'(n));
        check("stream_cen_lo", 32'(cen_lo), 32'(n));
        if (exp_early >= 0) check("stream_early_accepts", 32'(acc_early), 32'(exp_early));
        if (exp_last >= 0) check("stream_last_rsp_cycle", 32'(last_rsp), 32'(exp_last));
        @(posedge CLK); #1;
        drive_idle();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("stream_no_extra_rsp", 32'(bus.rsp_valid), 32'd0);
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'hC0DE_0000 | 32'(i);

        //         v     w     addr     wdata          be      rdy   cen   gwen  ben_n    a        d              rv    rdata
        vecs[0]  = '{1'b1, 1'b1, 13'h010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 13'h010, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 13'h010, 32'h12345678, 4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 13'h010, 32'h12345678, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 13'h000, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 13'h000, 32'h0,        1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 13'h000, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 13'h000, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b1, 13'h010, 32'h11223344, 4'h5, 1'b1, 1'b0, 1'b0, 4'hA, 13'h010, 32'h11223344, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 13'h010, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 13'h010, 32'h0,        1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 13'h020, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 13'h000, 32'h0,        1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 13'h000, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 13'h000, 32'h0,        1'b1, 32'hDE22BE44};
        vecs[8]  = '{1'b1, 1'b0, 13'h020, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 13'h020, 32'h0,        1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 13'h000, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 13'h000, 32'h0,        1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 13'h000, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 13'h000, 32'h0,        1'b1, 32'hC0DE0020};
        vecs[11] = '{1'b1, 1'b0, 13'h030, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 13'h030, 32'h0,        1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 13'h030, 32'hAAAA5555, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 13'h030, 32'hAAAA5555, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 13'h000, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 13'h000, 32'h0,        1'b1, 32'hC0DE0030};
        vecs[14] = '{1'b1, 1'b0, 13'h030, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 4'hF, 13'h030, 32'h0,        1'b0, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 13'h000, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 13'h000, 32'h0,        1'b0, 32'h0};
        vecs[16] = '{1'b0, 1'b1, 13'h000, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 13'h000, 32'h0,        1'b1, 32'hAAAA5555};

        drive_idle();
        bus.rsp_ready = 1'b1;
        RESETn = 1'b0;
        @(negedge CLK);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_cen_n", 32'(bus.sram_cen_n), 32'd1);
        repeat (2) @(posedge CLK);
        #1 RESETn = 1'b1;

        // Cycle table: write/read, partial byte enables, be=0 write, write-after-read ordering.
        for (int i = 0; i < 17; i++) begin
            @(posedge CLK); #1;
            bus.req_valid = vecs[i].valid;
            bus.req_write = vecs[i].write;
            bus.req_addr  = vecs[i].addr;
            bus.req_wdata = vecs[i].wdata;
            bus.req_be    = vecs[i].be;
            @(negedge CLK);
            check($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d_cen_n", i), 32'(bus.sram_cen_n), 32'(vecs[i].e_cen_n));
            check($sformatf("v%0d_gwen_n", i), 32'(bus.sram_gwen_n), 32'(vecs[i].e_gwen_n));
            check($sformatf("v%0d_ben_n", i), 32'(bus.sram_ben_n), 32'(vecs[i].e_ben_n));
            check($sformatf("v%0d_sram_a", i), 32'(bus.sram_a), 32'(vecs[i].e_a));
            check($sformatf("v%0d_sram_d", i), bus.sram_d, vecs[i].e_d);
            check($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].e_rsp_valid));
            if (vecs[i].e_rsp_valid) check($sformatf("v%0d_rsp_rdata", i), bus.rsp_rdata, vecs[i].e_rdata);
        end
        @(posedge CLK); #1;
        drive_idle();
        repeat (3) @(posedge CLK);

        // Back-to-back reads with the consumer always ready.
        run_stream(13'h000, 8, 0, (DEPTH == 2) ? 8 : 4, (DEPTH == 2) ? 9 : 16);
        // Consumer stalled for 10 cycles while reads keep coming.
        run_stream(13'h040, 6, 10, -1, -1);

        // Reset in the cycle after a read accept: the in-flight read must vanish.
        @(posedge CLK); #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 13'h050;
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        check("rst_rd_accept", 32'(bus.req_ready), 32'd1);
        @(posedge CLK); #1;
        bus.req_addr = 13'h051;
        RESETn = 1'b0;
        #1;
        check("rst_rsp_valid_now", 32'(bus.rsp_valid), 32'd0);
        check("rst_cen_forced", 32'(bus.sram_cen_n), 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            check("rst_cen_held", 32'(bus.sram_cen_n), 32'd1);
        end
        @(posedge CLK); #1;
        drive_idle();
        RESETn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("rst_no_late_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // Asynchronous reset while a response is held: valid and data clear at once.
        @(posedge CLK); #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 13'h052;
        bus.rsp_ready = 1'b0;
        @(negedge CLK);
        check("rst2_rd_accept", 32'(bus.req_ready), 32'd1);
        @(posedge CLK); #1;
        drive_idle();
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rst2_rsp_rdata", bus.rsp_rdata, 32'hC0DE0052);
        #2 RESETn = 1'b0;
        #1;
        check("rst2_valid_cleared", 32'(bus.rsp_valid), 32'd0);
        check("rst2_rdata_cleared", bus.rsp_rdata, 32'd0);
        @(posedge CLK); #1;
        RESETn = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("rst2_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
